// File: rtl/branch_resolve_queue.sv
`default_nettype none
//==============================================================================
// Module      : branch_resolve_queue
// Description : Resolution end of the direction predictor. Holds each fetched
//               branch (table index, predicted direction, PC) in program order
//               and, when execute resolves the oldest branch, emits a 2-bit
//               counter training update and, on a mispredict, a flush pulse
//               with the fetch restart PC. A mispredict squashes every
//               younger entry.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters  : DEPTH  in-flight entries (power of 2, >= 2)
//               IDX_W  history table index width
//               PC_W   PC / target width
// Ports       : clk, rst          clock, synchronous active-high reset
//               pred_valid/ready  fetch push handshake (ready = !full)
//               pred_idx/taken/pc predicted branch record
//               res_valid/taken   execute resolution of the oldest branch
//               res_target        actual taken target
//               upd_valid/idx/taken  registered training strobe
//               flush, redirect_pc   registered mispredict pulse / restart PC
//               count             entries held
//               err_underflow     sticky: resolution seen while empty
// Option      : BRQ_STATS_EN adds saturating counters stat_resolved and
//               stat_mispred (16 bits each).
//==============================================================================
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pred_valid,
    output logic                       pred_ready,
    input  logic [IDX_W-1:0]           pred_idx,
    input  logic                       pred_taken,
    input  logic [PC_W-1:0]            pred_pc,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic [PC_W-1:0]            res_target,
    output logic                       upd_valid,
    output logic [IDX_W-1:0]           upd_idx,
    output logic                       upd_taken,
    output logic                       flush,
    output logic [PC_W-1:0]            redirect_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err_underflow
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]                stat_resolved,
    output logic [15:0]                stat_mispred
`endif
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;

    // Bit 0 drives upd_valid, bit 1 drives flush, so both strobes come
    // straight from flops.
    localparam logic [1:0] c_ST_IDLE         = 2'b00;
    localparam logic [1:0] c_ST_UPDATE       = 2'b01;
    localparam logic [1:0] c_ST_UPDATE_FLUSH = 2'b11;

    // Entry storage (no reset needed: only slots between the pointers are read)
    logic [IDX_W-1:0] mem_idx   [DEPTH];
    logic             mem_taken [DEPTH];
    logic [PC_W-1:0]  mem_pc    [DEPTH];

    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   upd_idx_q, upd_idx_d;
    logic               upd_taken_q, upd_taken_d;
    logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;
    logic               err_underflow_q, err_underflow_d;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_mispredict;
    logic [IDX_W-1:0]   w_head_idx;
    logic               w_head_taken;
    logic [PC_W-1:0]    w_head_pc;

    // Equal index bits with differing wrap bits means the writer has lapped
    // the reader exactly once.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_ADDR_W] != rd_ptr_q[c_ADDR_W]) &&
                     (wr_ptr_q[c_ADDR_W-1:0] == rd_ptr_q[c_ADDR_W-1:0]);

    assign w_head_idx   = mem_idx[rd_ptr_q[c_ADDR_W-1:0]];
    assign w_head_taken = mem_taken[rd_ptr_q[c_ADDR_W-1:0]];
    assign w_head_pc    = mem_pc[rd_ptr_q[c_ADDR_W-1:0]];

    assign pred_ready   = !w_full;
    assign w_push       = pred_valid && pred_ready;
    assign w_pop        = res_valid && !w_empty;
    assign w_mispredict = w_pop && (w_head_taken != res_taken);

    always_comb begin
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        state_d         = c_ST_IDLE;
        upd_idx_d       = upd_idx_q;
        upd_taken_d     = upd_taken_q;
        redirect_pc_d   = redirect_pc_q;
        err_underflow_d = err_underflow_q || (res_valid && w_empty);

        // A mispredict empties the queue, which also drops any push offered
        // in the same cycle.
        if (w_mispredict) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
        end

        if (w_pop) begin
            upd_idx_d   = w_head_idx;
            upd_taken_d = res_taken;
            state_d     = w_mispredict ? c_ST_UPDATE_FLUSH : c_ST_UPDATE;
            if (w_mispredict) begin
                redirect_pc_d = res_taken ? res_target : (w_head_pc + PC_W'(4));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            state_q         <= c_ST_IDLE;
            upd_idx_q       <= '0;
            upd_taken_q     <= 1'b0;
            redirect_pc_q   <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            state_q         <= state_d;
            upd_idx_q       <= upd_idx_d;
            upd_taken_q     <= upd_taken_d;
            redirect_pc_q   <= redirect_pc_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_idx[wr_ptr_q[c_ADDR_W-1:0]]   <= pred_idx;
            mem_taken[wr_ptr_q[c_ADDR_W-1:0]] <= pred_taken;
            mem_pc[wr_ptr_q[c_ADDR_W-1:0]]    <= pred_pc;
        end
    end

    assign upd_valid     = state_q[0];
    assign flush         = state_q[1];
    assign upd_idx       = upd_idx_q;
    assign upd_taken     = upd_taken_q;
    assign redirect_pc   = redirect_pc_q;
    assign count         = wr_ptr_q - rd_ptr_q;
    assign err_underflow = err_underflow_q;

`ifdef BRQ_STATS_EN
    logic [15:0] stat_resolved_q, stat_resolved_d;
    logic [15:0] stat_mispred_q, stat_mispred_d;

    always_comb begin
        stat_resolved_d = stat_resolved_q;
        stat_mispred_d  = stat_mispred_q;
        if (w_pop && (stat_resolved_q != 16'hFFFF)) begin
            stat_resolved_d = stat_resolved_q + 16'd1;
        end
        if (w_mispredict && (stat_mispred_q != 16'hFFFF)) begin
            stat_mispred_d = stat_mispred_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_resolved_q <= stat_resolved_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
//==============================================================================
// Module      : tb_branch_resolve_queue
// Description : Directed self-checking bench for branch_resolve_queue
//               (DEPTH=4, IDX_W=8, PC_W=32). Inputs change 1ns after the
//               rising edge; outputs are sampled 1ns after the following edge.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_branch_resolve_queue;

    logic        clk;
    logic        rst;
    logic        pred_valid;
    logic        pred_ready;
    logic [7:0]  pred_idx;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        upd_valid;
    logic [7:0]  upd_idx;
    logic        upd_taken;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [2:0]  count;
    logic        err_underflow;
`ifdef BRQ_STATS_EN
    logic [15:0] stat_resolved;
    logic [15:0] stat_mispred;
`endif

    int checks   = 0;
    int failures = 0;

    branch_resolve_queue #(.DEPTH(4), .IDX_W(8), .PC_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_valid    (pred_valid),
        .pred_ready    (pred_ready),
        .pred_idx      (pred_idx),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .res_target    (res_target),
        .upd_valid     (upd_valid),
        .upd_idx       (upd_idx),
        .upd_taken     (upd_taken),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .count         (count),
        .err_underflow (err_underflow)
`ifdef BRQ_STATS_EN
        ,
        .stat_resolved (stat_resolved),
        .stat_mispred  (stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic push(input logic [7:0] idx, input logic tk, input logic [31:0] pc);
        pred_valid = 1'b1;
        pred_idx   = idx;
        pred_taken = tk;
        pred_pc    = pc;
        res_valid  = 1'b0;
        step();
        pred_valid = 1'b0;
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tgt);
        res_valid  = 1'b1;
        res_taken  = tk;
        res_target = tgt;
        pred_valid = 1'b0;
        step();
        res_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pred_valid = 1'b0; pred_idx = '0; pred_taken = 1'b0; pred_pc = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_count", 64'(count), 64'd0);
        check("rst_upd_valid", 64'(upd_valid), 64'd0);
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_redirect", 64'(redirect_pc), 64'd0);
        check("rst_err", 64'(err_underflow), 64'd0);
        check("rst_ready", 64'(pred_ready), 64'd1);

        // Correct prediction
        push(8'h05, 1'b1, 32'h100);
        check("t1_count_push", 64'(count), 64'd1);
        resolve(1'b1, 32'h0);
        check("t1_upd_valid", 64'(upd_valid), 64'd1);
        check("t1_upd_idx", 64'(upd_idx), 64'h05);
        check("t1_upd_taken", 64'(upd_taken), 64'd1);
        check("t1_flush", 64'(flush), 64'd0);
        check("t1_count", 64'(count), 64'd0);
        step();
        check("t1_upd_pulse", 64'(upd_valid), 64'd0);

        // Predicted taken, actually not taken: restart at pc+4
        push(8'h07, 1'b1, 32'h200);
        resolve(1'b0, 32'h999);
        check("t2_flush", 64'(flush), 64'd1);
        check("t2_redirect", 64'(redirect_pc), 64'h204);
        check("t2_upd_taken", 64'(upd_taken), 64'd0);
        check("t2_upd_idx", 64'(upd_idx), 64'h07);
        check("t2_count", 64'(count), 64'd0);
        step();
        check("t2_flush_pulse", 64'(flush), 64'd0);
        check("t2_redirect_hold", 64'(redirect_pc), 64'h204);

        // Mispredict squashes younger entries; extra resolve underflows
        push(8'h01, 1'b0, 32'h10);
        push(8'h02, 1'b0, 32'h20);
        push(8'h03, 1'b0, 32'h30);
        check("t3_count3", 64'(count), 64'd3);
        resolve(1'b1, 32'h400);
        check("t3_flush", 64'(flush), 64'd1);
        check("t3_redirect", 64'(redirect_pc), 64'h400);
        check("t3_upd_idx", 64'(upd_idx), 64'h01);
        check("t3_count0", 64'(count), 64'd0);
        check("t3_err_before", 64'(err_underflow), 64'd0);
        resolve(1'b1, 32'h500);
        check("t3_ign_upd", 64'(upd_valid), 64'd0);
        check("t3_ign_flush", 64'(flush), 64'd0);
        check("t3_ign_redirect", 64'(redirect_pc), 64'h400);
        check("t3_err", 64'(err_underflow), 64'd1);

        // Fill, full behaviour, wrap-around ordering
        push(8'h10, 1'b1, 32'h1000);
        push(8'h11, 1'b1, 32'h1010);
        push(8'h12, 1'b1, 32'h1020);
        push(8'h13, 1'b1, 32'h1030);
        check("t4_full_count", 64'(count), 64'd4);
        check("t4_full_ready", 64'(pred_ready), 64'd0);
        push(8'h14, 1'b1, 32'h1040);
        check("t4_reject_count", 64'(count), 64'd4);
        // Pop plus push while full: push still rejected this cycle
        pred_valid = 1'b1; pred_idx = 8'h14; pred_taken = 1'b1; pred_pc = 32'h1040;
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        res_valid = 1'b0;
        check("t4_sim_count", 64'(count), 64'd3);
        check("t4_sim_upd_idx", 64'(upd_idx), 64'h10);
        step();
        pred_valid = 1'b0;
        check("t4_push_after", 64'(count), 64'd4);
        resolve(1'b1, 32'h0);
        check("t4_pop_idx", 64'(upd_idx), 64'h11);
        check("t4_pop_count", 64'(count), 64'd3);
        for (int i = 0; i < 6; i++) begin
            pred_valid = 1'b1; pred_idx = 8'h15 + 8'(i); pred_taken = 1'b1;
            pred_pc = 32'h2000 + 32'(i);
            res_valid = 1'b1; res_taken = 1'b1;
            step();
            check($sformatf("t4_pair%0d_idx", i), 64'(upd_idx), 64'(8'h12 + 8'(i)));
            check($sformatf("t4_pair%0d_count", i), 64'(count), 64'd3);
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            resolve(1'b1, 32'h0);
            check($sformatf("t4_drain%0d_idx", i), 64'(upd_idx), 64'(8'h18 + 8'(i)));
            check($sformatf("t4_drain%0d_flush", i), 64'(flush), 64'd0);
        end
        check("t4_drained", 64'(count), 64'd0);

        // Mispredict drops a same-cycle push
        push(8'h08, 1'b1, 32'h3000);
        pred_valid = 1'b1; pred_idx = 8'h09; pred_taken = 1'b1; pred_pc = 32'h3100;
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        idle_inputs();
        check("t5_flush", 64'(flush), 64'd1);
        check("t5_redirect", 64'(redirect_pc), 64'h3004);
        check("t5_count", 64'(count), 64'd0);
        push(8'h0A, 1'b1, 32'h3200);
        check("t5_count_next", 64'(count), 64'd1);
        resolve(1'b1, 32'h0);
        check("t5_next_idx", 64'(upd_idx), 64'h0A);

        // Reset mid-operation
        push(8'h20, 1'b0, 32'h4000);
        push(8'h21, 1'b0, 32'h4010);
        check("t6_count2", 64'(count), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_count", 64'(count), 64'd0);
        check("t6_upd_valid", 64'(upd_valid), 64'd0);
        check("t6_upd_idx", 64'(upd_idx), 64'd0);
        check("t6_upd_taken", 64'(upd_taken), 64'd0);
        check("t6_flush", 64'(flush), 64'd0);
        check("t6_redirect", 64'(redirect_pc), 64'd0);
        check("t6_err", 64'(err_underflow), 64'd0);
        step();
        check("t6_quiet_upd", 64'(upd_valid), 64'd0);

`ifdef BRQ_STATS_EN
        for (int i = 0; i < 3; i++) begin
            push(8'(8'h30 + i), 1'b1, 32'h5000);
            resolve(1'b1, 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            push(8'(8'h40 + i), 1'b1, 32'h6000);
            resolve(1'b0, 32'h0);
        end
        check("stat_resolved", 64'(stat_resolved), 64'd5);
        check("stat_mispred", 64'(stat_mispred), 64'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Resolution end of the direction predictor. Records each fetched branch's table index, predicted direction and PC in order.
- When the branch outcome arrives from execute, it compares outcome with the prediction. It then emits a 2-bit-counter training update to the history table and, on mismatch, a flush plus redirect PC to fetch.
- Sits between the fetch-stage predictor lookup and the execute-stage branch unit.

Parameters:
DEPTH, 4, in-flight branch entries; power of 2, >= 2
IDX_W, 8, history table index width
PC_W, 32, PC/target width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pred_valid  in  1  fetch presents a predicted branch
pred_ready  out  1  queue accepts the branch (combinational: !full)
pred_idx  in  IDX_W  table index used for the lookup
pred_taken  in  1  predicted direction
pred_pc  in  PC_W  branch PC
res_valid  in  1  execute resolves the oldest outstanding branch
res_taken  in  1  actual direction
res_target  in  PC_W  actual taken target
upd_valid  out  1  training strobe to history table
upd_idx  out  IDX_W  index to train
upd_taken  out  1  actual direction for training
flush  out  1  mispredict pulse
redirect_pc  out  PC_W  fetch restart PC, valid when flush=1
count  out  $clog2(DEPTH)+1  entries held
err_underflow  out  1  sticky: res_valid seen while empty

Behaviour:
- Storage: circular buffer with rd/wr pointers of $clog2(DEPTH)+1 bits. The MSB distinguishes full from empty. Wrap is modulo 2*DEPTH on the pointers and modulo DEPTH on the array index.
- Push: pred_valid && pred_ready writes {pred_idx, pred_taken, pred_pc} at wr_ptr, then wr_ptr+1.
- Pop: res_valid && !empty reads the head, then rd_ptr+1.
- Simultaneous push and pop with no mispredict: both happen and count is unchanged. When full, pred_ready=0 in that cycle; there is no same-cycle bypass.
- Mispredict = head.pred_taken != res_taken.
- All outputs are registered, with 1-cycle latency from the resolving edge:
  - upd_valid=1, upd_idx=head.pred_idx, upd_taken=res_taken for every accepted resolution, correct or not.
  - On mispredict: flush=1. redirect_pc=res_target if res_taken, else head.pred_pc+4 (wraps modulo 2^PC_W).
  - On a correct prediction, flush=0 and redirect_pc holds its previous value.
  - upd_valid and flush are single-cycle pulses.
- Mispredict squash, on the same resolving edge:
  - rd_ptr and wr_ptr both go to 0 and count to 0; all younger entries are discarded.
  - A push offered in the same cycle is dropped, even though pred_ready was 1. Fetch must treat flush as squashing it.
- res_valid while empty: ignored (no pop, no update, no flush). err_underflow is set on the next edge and cleared only by rst.
- Reset: pointers=0, count=0, upd_valid=0, upd_idx=0, upd_taken=0, flush=0, redirect_pc=0, err_underflow=0. Array contents are don't-care. Reset mid-operation discards all entries with no update or flush emitted.
- FSM per resolution: IDLE (no output) -> UPDATE (upd only) or UPDATE_FLUSH (upd+flush) for one cycle -> IDLE. Back-to-back resolutions keep the strobes asserted on consecutive cycles.

Optional Feature:
- Macro BRQ_STATS_EN.
- When defined, adds outputs stat_resolved[15:0] and stat_mispred[15:0]:
  - stat_resolved increments on each accepted resolution.
  - stat_mispred increments on each mispredict.
  - Both saturate at 16'hFFFF, reset to 0 on rst, and update on the same edge as the pop.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Push idx 8'h05 taken=1 pc 32'h100, then res_valid taken=1 -> next cycle upd_valid=1, upd_idx=8'h05, upd_taken=1, flush=0, count 1->0.
- Push idx 8'h07 taken=1 pc 32'h200, resolve taken=0 -> flush=1, redirect_pc=32'h204, upd_taken=0, count=0.
- Push 3 entries (idx 1,2,3, all taken=0), resolve first with taken=1 target 32'h400 -> flush=1, redirect_pc=32'h400, upd_idx=1, count=0; next resolution is ignored and err_underflow=1.
- Fill DEPTH=4 entries -> pred_ready=0, extra push ignored. Simultaneous correct resolve plus push -> push still rejected that cycle, count=3; next cycle push accepted, count=4. Drain 6 more push/pop pairs across the wrap boundary -> FIFO order of upd_idx preserved.
- Mispredict resolve in the same cycle as a push of idx 8'h09 -> entry dropped, count=0, no later upd_idx=8'h09.
- rst asserted with 2 entries queued -> count=0, all outputs 0. With BRQ_STATS_EN: after 3 correct and 2 mispredicted resolutions -> stat_resolved=5, stat_mispred=2.
